// File: rtl/mont_top.sv
// Bit-serial radix-2 Montgomery multiplier: result = x*y*2^-WIDTH mod n.
// Define MONT_FINAL_SUB_EN for the final conditional subtraction (SUB state).
module mont_top #(
  parameter int WIDTH = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic             finish,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SUB,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [WIDTH-1:0] nr;
  logic [WIDTH+1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] acc_add;
  logic [WIDTH+1:0] acc_red;
  logic [WIDTH+1:0] acc_nxt;
  logic             last;

  // xr shifts right each iteration, so xr[0] is x[i]
  assign acc_add = acc + (xr[0] ? {2'b00, yr} : '0);
  assign acc_red = acc_add + (acc_add[0] ? {2'b00, nr} : '0);
  assign acc_nxt = acc_red >> 1;
  assign last    = (cnt == CW'(WIDTH - 1));

`ifdef MONT_FINAL_SUB_EN
  logic             acc_ge;
  logic [WIDTH-1:0] sub_val;

  assign acc_ge  = (acc >= {2'b00, nr});
  assign sub_val = acc_ge ? (acc[WIDTH-1:0] - nr) : acc[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      finish <= 1'b0;
      result <= '0;
      xr     <= '0;
      yr     <= '0;
      nr     <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            xr    <= x;
            yr    <= y;
            nr    <= n;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          xr  <= xr >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
`ifdef MONT_FINAL_SUB_EN
            state  <= SUB;
`else
            result <= acc_nxt[WIDTH-1:0];
            finish <= 1'b1;
            state  <= DONE;
`endif
          end
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: begin
          result <= sub_val;
          finish <= 1'b1;
          state  <= DONE;
        end
`endif
        DONE: begin
          if (!enable) begin
            finish <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_top.sv
// Bench for mont_top: 8-bit and 2048-bit instances against a modular model.
// Accepts either build of MONT_FINAL_SUB_EN.
module tb_mont_top;

`ifdef MONT_FINAL_SUB_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif
  localparam int LAT8  = 8 + (FULL ? 1 : 0);
  localparam int LAT2K = 2048 + (FULL ? 1 : 0);

  logic          clk;
  logic          rst;
  logic          en8;
  logic          en2k;
  logic [7:0]    x8, y8, n8, r8;
  logic          fin8;
  logic [2047:0] x2k, y2k, n2k, r2k;
  logic          fin2k;

  int n_cmp = 0;
  int n_bad = 0;

  mont_top #(.WIDTH(8)) u_m8 (
    .clk(clk), .rst(rst), .enable(en8),
    .x(x8), .y(y8), .n(n8),
    .finish(fin8), .result(r8)
  );

  mont_top #(.WIDTH(2048)) u_m2k (
    .clk(clk), .rst(rst), .enable(en2k),
    .x(x2k), .y(y2k), .n(n2k),
    .finish(fin2k), .result(r2k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [2047:0] obs,
                     input logic [2047:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // x*y*2^-w mod m: reduce the product, then halve w times modulo m
  function automatic logic [2047:0] mont_ref(input logic [2047:0] a,
                                             input logic [2047:0] b,
                                             input logic [2047:0] m,
                                             input int w);
    logic [4095:0] p;
    logic [2048:0] v;
    p = {2048'b0, a} * {2048'b0, b};
    p = p % {2048'b0, m};
    v = {1'b0, p[2047:0]};
    for (int k = 0; k < w; k++) begin
      if (v[0]) v = v + {1'b0, m};
      v = v >> 1;
    end
    return v[2047:0];
  endfunction

  // Without final subtraction the result may be exp+n (kept to w bits)
  function automatic logic [2047:0] norm(input logic [2047:0] got,
                                         input logic [2047:0] exp,
                                         input logic [2047:0] m,
                                         input int w);
    logic [2048:0] one;
    logic [2048:0] mask;
    logic [2048:0] alt;
    if (FULL) return got;
    one  = 1;
    mask = (one << w) - 1;
    alt  = ({1'b0, exp} + {1'b0, m}) & mask;
    return (got == alt[2047:0]) ? exp : got;
  endfunction

  task automatic run8(input logic [7:0] xv, input logic [7:0] yv,
                      input logic [7:0] nv, input bit drop,
                      input bit scr, input bit chk_val,
                      input int hold);
    int            cnt;
    bit            stable;
    logic [2047:0] ew;
    ew = mont_ref({2040'b0, xv}, {2040'b0, yv}, {2040'b0, nv}, 8);
    @(negedge clk);
    x8 = xv; y8 = yv; n8 = nv; en8 = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    if (drop) en8 = 1'b0;
    while (!fin8 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (scr && cnt == 3) begin
        x8 = 8'($urandom); y8 = 8'($urandom); n8 = 8'($urandom);
      end
    end
    chk("lat8", 2048'(cnt), 2048'(LAT8));
    if (chk_val)
      chk("res8", norm({2040'b0, r8}, ew, {2040'b0, nv}, 8), ew);
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        if (!fin8) stable = 1'b0;
        if (norm({2040'b0, r8}, ew, {2040'b0, nv}, 8) != ew)
          stable = 1'b0;
      end
      chk("hold8", 2048'(stable), 2048'(1));
    end
    if (!drop) en8 = 1'b0;
    @(posedge clk);
    #1;
    chk("fin8_clr", 2048'(fin8), 2048'(0));
    if (chk_val)
      chk("keep8", norm({2040'b0, r8}, ew, {2040'b0, nv}, 8), ew);
  endtask

  task automatic run2k(input bit drop);
    int            cnt;
    logic [2047:0] xv, yv, nv, ew;
    for (int k = 0; k < 64; k++) begin
      xv[k*32 +: 32] = $urandom;
      yv[k*32 +: 32] = $urandom;
      nv[k*32 +: 32] = $urandom;
    end
    nv[2047] = 1'b1;
    nv[0]    = 1'b1;
    xv[2047] = 1'b0;
    yv[2047] = 1'b0;
    ew = mont_ref(xv, yv, nv, 2048);
    @(negedge clk);
    x2k = xv; y2k = yv; n2k = nv; en2k = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    if (drop) en2k = 1'b0;
    while (!fin2k && cnt < 2100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 5) begin
        x2k = ~x2k; y2k = ~y2k;
      end
    end
    chk("lat2k", 2048'(cnt), 2048'(LAT2K));
    chk("res2k", norm(r2k, ew, nv, 2048), ew);
    if (!drop) en2k = 1'b0;
    @(posedge clk);
    #1;
    chk("fin2k_clr", 2048'(fin2k), 2048'(0));
    chk("keep2k", norm(r2k, ew, nv, 2048), ew);
  endtask

  initial begin
    logic [7:0] nr, xr, yr;
    rst  = 1'b0;
    en8  = 1'b0;
    en2k = 1'b0;
    x8 = '0; y8 = '0; n8 = '0;
    x2k = '0; y2k = '0; n2k = '0;
    #12;
    chk("rst_fin8", 2048'(fin8), 2048'(0));
    chk("rst_r8", {2040'b0, r8}, 2048'(0));
    chk("rst_fin2k", 2048'(fin2k), 2048'(0));
    chk("rst_r2k", r2k, 2048'(0));
    @(negedge clk);
    rst = 1'b1;

    run8(8'd1, 8'd1, 8'd13, 1'b0, 1'b0, 1'b1, 0);
    run8(8'd9, 8'd5, 8'd13, 1'b0, 1'b0, 1'b1, 0);
    run8(8'd12, 8'd12, 8'd13, 1'b0, 1'b0, 1'b1, 0);
    run8(8'd0, 8'd7, 8'd13, 1'b0, 1'b0, 1'b1, 0);
    run8(8'd9, 8'd5, 8'd13, 1'b0, 1'b0, 1'b1, 120);
    run8(8'd1, 8'd1, 8'd13, 1'b0, 1'b1, 1'b1, 0);
    run8(8'd1, 8'd1, 8'd13, 1'b1, 1'b0, 1'b1, 0);
    for (int t = 0; t < 24; t++) begin
      nr = 8'($urandom_range(1, 127) * 2 + 1);
      xr = 8'($urandom_range(0, int'(nr) - 1));
      yr = 8'($urandom_range(0, int'(nr) - 1));
      run8(xr, yr, nr, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1, 0);
    end
    run8(8'd200, 8'd77, 8'd12, 1'b0, 1'b0, 1'b0, 0);

    run2k(1'b0);
    run2k(1'b1);
    run2k(1'b0);

    @(negedge clk);
    x8 = 8'd1; y8 = 8'd1; n8 = 8'd13; en8 = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_fin8", 2048'(fin8), 2048'(0));
    chk("mid_r8", {2040'b0, r8}, 2048'(0));
    chk("mid_r2k", r2k, 2048'(0));
    en8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run8(8'd1, 8'd1, 8'd13, 1'b0, 1'b0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mont_top.md
# mont_top

Bit-serial radix-2 Montgomery modular multiplier computing `result = x·y·2^-WIDTH mod n` for a WIDTH-bit odd modulus. It is the core arithmetic block of the RSA datapath; the exponentiation controller calls it repeatedly for each modular multiply.

## Interface

- `WIDTH`, default 2048: operand/modulus width in bits.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: start request, level-sensitive, sampled in IDLE.
- `x`, input, WIDTH: multiplicand, requirement `x < n`.
- `y`, input, WIDTH: multiplier, requirement `y < n`.
- `n`, input, WIDTH: modulus, requirement odd and `n > 1`.
- `finish`, output, 1: result valid, held high in DONE.
- `result`, output, WIDTH: Montgomery product.

## Operation

- States: IDLE, CALC, SUB, DONE.
- IDLE, when `enable`=1 at a clock edge:
  - latch x, y and n internally;
  - accumulator A (WIDTH+2 bits) cleared to 0;
  - bit counter i cleared to 0;
  - go to CALC.
- IDLE with `enable`=0: stay in IDLE.
- CALC, one iteration per cycle for i = 0..WIDTH-1:
  - `A = A + x[i]·y`;
  - if the new A is odd, `A = A + n`;
  - `A = A >> 1`;
  - after iteration WIDTH-1, go to SUB.
- Input changes after the start edge are ignored because operands are latched.
- SUB: `result = (A >= n) ? A - n : A`, truncated to WIDTH bits. Set `finish`=1 and go to DONE.
- DONE:
  - hold `finish`=1 and `result`;
  - `enable`=0 → IDLE, with `finish` cleared on that edge and `result` retained until the next start;
  - `enable`=1 → stay in DONE, so no automatic restart.
- Deasserting `enable` during CALC or SUB has no effect; the operation completes.
- Arithmetic invariant: A < 2n throughout, so WIDTH+2 bits never overflow.
- Out-of-range inputs (even n, or x,y ≥ n) give an unspecified result, but the block must not hang: timing is identical.

## Timing

- Reset (`rst`=0, asynchronous): state IDLE, `finish`=0, `result`=0, A=0, i=0. This applies mid-operation too: any in-flight computation is discarded.
- Latency: the start edge is edge 0. CALC occupies edges 1..WIDTH, and SUB is at edge WIDTH+1.
- `finish` rises after edge WIDTH+1: 2049 cycles for WIDTH=2048, 9 cycles for WIDTH=8.
- `result` is registered and changes only on the SUB edge or on reset.
- Throughput: one product per WIDTH+3 cycles minimum, including the DONE→IDLE edge and a new start.

## Configuration

- `MONT_FINAL_SUB_EN`, defined (production builds must define it):
  - SUB state present;
  - `result` fully reduced, in the range [0, n);
  - latency as in Timing.
- Not defined:
  - SUB state removed;
  - after the last CALC iteration, `result = A[WIDTH-1:0]`, `finish`=1, DONE;
  - result is congruent mod n but only guaranteed to be < 2n;
  - latency is one cycle less (WIDTH edges after start).
  - Callers must then tolerate redundant representation.

## Test plan

- WIDTH=8, n=13 (R=256, R⁻¹ mod 13 = 3), x=1, y=1, start → `finish` after 9 cycles, `result`=3.
- WIDTH=8, n=13, x=9 (R mod n), y=5 → `result`=5. Also x=12, y=12 → `result`=3. Also x=0, y=7 → `result`=0.
- WIDTH=2048, random odd 2048-bit n with top bit set, random x,y < n → `result` equals golden `x·y·2^-2048 mod n`, and `finish` rises 2049 cycles after start.
- Hold `enable`=1 after finish → `finish` and `result` stay stable for 100+ cycles with no restart. Drop `enable` → `finish`=0 next edge and `result` unchanged.
- Assert `rst`=0 at cycle 4 of CALC → `finish`=0 and `result`=0 immediately, without waiting for a clock. Release and restart with WIDTH=8, n=13, x=y=1 → correct `result`=3 with full latency.
- Change x, y, n during CALC (WIDTH=8, n=13, x=y=1) → `result` still 3.
